// File: rtl/scrambler_par.sv
// Parametrised LFSR scrambler/descrambler processing DATA_W bits per clock, MSB first.
// Supports additive or self-synchronising operation and an optional automatic per-frame reseed.
module scrambler_par #(
    parameter int                LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] POLY      = 7'h48,
    parameter int                DATA_W    = 8,
    parameter int                MODE      = 0,
    parameter int                FRAME_LEN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    input  logic              load,
    input  logic              descramble,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_sof,
    output logic              seed_err
);

    localparam int                CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (FRAME_LEN > 0) ? CNT_W'(FRAME_LEN - 1) : '0;
    localparam logic [LFSR_W-1:0] ONES     = '1;

    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] s_step;
    logic [LFSR_W-1:0] seed_fix;
    logic [DATA_W-1:0] word_step;
    logic [CNT_W-1:0]  cnt;
    logic              sof_pending;
    logic              self_sync_rx;
    logic              seed_zero;
    logic              accept;
    logic              frame_end;
    logic              fb;
    logic              ob;
    logic              nb;

    // Handshake: a word is accepted when din_valid=1 and load=0; there is no backpressure,
    // and each accepted word yields dout_valid exactly one clock later.
    assign accept = din_valid && !load;

    // An all-zero state would lock the LFSR, except on a self-synchronising receiver
    // whose state is refilled from the line.
    assign self_sync_rx = (MODE == 1) && descramble;
    assign seed_zero    = (seed == '0) && !self_sync_rx;
    assign seed_fix     = seed_zero ? ONES : seed;

    assign frame_end = (FRAME_LEN > 0) && accept && (cnt == CNT_LAST);

    // DATA_W chained single-bit steps, unrolled within one cycle.
    always_comb begin
        s_step    = s;
        word_step = '0;
        fb        = 1'b0;
        ob        = 1'b0;
        nb        = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb           = ^(s_step & POLY);
            ob           = din[i] ^ fb;
            word_step[i] = ob;
            if (MODE == 0) begin
                nb = fb;
            end else if (self_sync_rx) begin
                nb = din[i];
            end else begin
                nb = ob;
            end
            s_step = {s_step[LFSR_W-2:0], nb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s           <= ONES;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_sof    <= 1'b0;
            seed_err    <= 1'b0;
            cnt         <= '0;
            sof_pending <= 1'b1;
        end else begin
            dout_valid <= accept;
            dout_sof   <= accept && sof_pending;
            seed_err   <= load && seed_zero;
            if (accept) begin
                dout <= word_step;
            end
            if (load) begin
                s           <= seed_fix;
                cnt         <= '0;
                sof_pending <= 1'b1;
            end else if (accept) begin
                // The last word of a frame is scrambled with the running state, then the LFSR restarts.
                if (frame_end) begin
                    s           <= seed_fix;
                    cnt         <= '0;
                    sof_pending <= 1'b1;
                end else begin
                    s           <= s_step;
                    sof_pending <= 1'b0;
                    if (FRAME_LEN > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scrambler_par.sv
// Bench for scrambler_par: four instances (additive, additive with frame reload, self-sync TX and RX)
// checked by a scoreboard against a sequence-recurrence reference model.
module tb_scrambler_par;

    localparam int         LW   = 7;
    localparam int         DW   = 8;
    localparam logic [6:0] POLY = 7'h48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] a_seed, f_seed, t_seed, r_seed;
    logic       a_load, f_load, t_load, r_load;
    logic       a_desc, f_desc, t_desc, r_desc;
    logic [7:0] a_din, f_din, t_din;
    logic       a_vi, f_vi, t_vi;
    logic [7:0] a_dout, f_dout, t_dout, r_dout;
    logic       a_vo, f_vo, t_vo, r_vo;
    logic       a_sof, f_sof, t_sof, r_sof;
    logic       a_err, f_err, t_err, r_err;

    scrambler_par #(.LFSR_W(7), .POLY(7'h48), .DATA_W(8), .MODE(0), .FRAME_LEN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .seed(a_seed), .load(a_load), .descramble(a_desc),
        .din(a_din), .din_valid(a_vi), .dout(a_dout), .dout_valid(a_vo),
        .dout_sof(a_sof), .seed_err(a_err));

    scrambler_par #(.LFSR_W(7), .POLY(7'h48), .DATA_W(8), .MODE(0), .FRAME_LEN(3)) u_f (
        .clk(clk), .rst_n(rst_n), .seed(f_seed), .load(f_load), .descramble(f_desc),
        .din(f_din), .din_valid(f_vi), .dout(f_dout), .dout_valid(f_vo),
        .dout_sof(f_sof), .seed_err(f_err));

    scrambler_par #(.LFSR_W(7), .POLY(7'h48), .DATA_W(8), .MODE(1), .FRAME_LEN(0)) u_tx (
        .clk(clk), .rst_n(rst_n), .seed(t_seed), .load(t_load), .descramble(t_desc),
        .din(t_din), .din_valid(t_vi), .dout(t_dout), .dout_valid(t_vo),
        .dout_sof(t_sof), .seed_err(t_err));

    scrambler_par #(.LFSR_W(7), .POLY(7'h48), .DATA_W(8), .MODE(1), .FRAME_LEN(0)) u_rx (
        .clk(clk), .rst_n(rst_n), .seed(r_seed), .load(r_load), .descramble(r_desc),
        .din(t_dout), .din_valid(t_vo), .dout(r_dout), .dout_valid(r_vo),
        .dout_sof(r_sof), .seed_err(r_err));

    typedef struct {
        logic [7:0] data;
        bit         sof;
        int         cyc;
        bit         chk;
        logic [7:0] plain;
    } exp_t;

    exp_t q_a[$];
    exp_t q_f[$];
    exp_t q_t[$];
    exp_t q_r[$];
    bit   err_exp[int];

    int tests = 0;
    int fails = 0;
    int tx_idx = 0;
    bit tx_on = 0;

    // Reference model: each channel is a bit sequence x[n] where x[n] = XOR of x[n-1-i] over taps i
    // (additive), or the transmitted/received line bit (self-sync). Channels: 0=A 1=F 2=TX 3=RX.
    bit seq[4][8192];
    int len[4];
    int cnt[4];
    bit sofp[4];
    int flen[4] = '{0, 3, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic m_seed(input int ch, input logic [6:0] sd);
        logic [6:0] v;
        v = (sd == 7'd0 && ch != 3) ? 7'h7F : sd;
        len[ch] = 0;
        for (int i = LW - 1; i >= 0; i--) begin
            seq[ch][len[ch]] = v[i];
            len[ch]++;
        end
        cnt[ch]  = 0;
        sofp[ch] = 1'b1;
    endtask

    task automatic m_word(input int ch, input logic [7:0] d, input logic [6:0] sd,
                          output logic [7:0] o, output bit sof);
        logic [6:0] p;
        bit         f;
        bit         nb;
        p = POLY;
        o = '0;
        if (len[ch] > 8000) begin
            for (int i = 0; i < LW; i++) seq[ch][i] = seq[ch][len[ch] - LW + i];
            len[ch] = LW;
        end
        for (int j = DW - 1; j >= 0; j--) begin
            f = 1'b0;
            for (int i = 0; i < LW; i++) if (p[i]) f ^= seq[ch][len[ch] - 1 - i];
            o[j] = d[j] ^ f;
            nb = (ch < 2) ? f : ((ch == 2) ? o[j] : d[j]);
            seq[ch][len[ch]] = nb;
            len[ch]++;
        end
        sof      = sofp[ch];
        sofp[ch] = 1'b0;
        if (flen[ch] > 0) begin
            cnt[ch]++;
            if (cnt[ch] == flen[ch]) m_seed(ch, sd);
        end
    endtask

    task automatic load_ch(input int ch, input logic [6:0] sd);
        case (ch)
            0: begin a_load = 1'b1; a_seed = sd; end
            1: begin f_load = 1'b1; f_seed = sd; end
            2: begin t_load = 1'b1; t_seed = sd; end
            default: begin r_load = 1'b1; r_seed = sd; end
        endcase
        m_seed(ch, sd);
        if (sd == 7'd0 && ch != 3) err_exp[ch * 1000000 + cyc + 1] = 1'b1;
    endtask

    task automatic feed_a(input logic [7:0] d, input bit use_c, input logic [7:0] c);
        logic [7:0] o;
        bit         s;
        exp_t       e;
        a_din = d;
        a_vi  = 1'b1;
        m_word(0, d, a_seed, o, s);
        e.data = use_c ? c : o; e.sof = s; e.cyc = cyc + 1; e.chk = 1'b0; e.plain = '0;
        q_a.push_back(e);
    endtask

    task automatic feed_f(input logic [7:0] d, input bit use_c, input logic [7:0] c);
        logic [7:0] o;
        bit         s;
        exp_t       e;
        f_din = d;
        f_vi  = 1'b1;
        m_word(1, d, f_seed, o, s);
        e.data = use_c ? c : o; e.sof = s; e.cyc = cyc + 1; e.chk = 1'b0; e.plain = '0;
        q_f.push_back(e);
    endtask

    task automatic feed_t(input logic [7:0] d);
        logic [7:0] o, o2;
        bit         s, s2;
        exp_t       e;
        t_din = d;
        t_vi  = 1'b1;
        m_word(2, d, t_seed, o, s);
        e.data = o; e.sof = s; e.cyc = cyc + 1; e.chk = 1'b0; e.plain = '0;
        q_t.push_back(e);
        m_word(3, o, r_seed, o2, s2);
        e.data = o2; e.sof = s2; e.cyc = cyc + 2; e.chk = (tx_idx >= 1); e.plain = d;
        q_r.push_back(e);
        tx_idx++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        a_load = 1'b0; a_vi = 1'b0;
        f_load = 1'b0; f_vi = 1'b0;
        t_load = 1'b0; t_vi = 1'b0;
        r_load = 1'b0;
        if (tx_on && tx_idx < 64 && $urandom_range(0, 4) != 0) feed_t(8'($urandom_range(0, 255)));
    endtask

    // Monitors: pop and compare whenever an instance presents dout_valid.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            if (a_vo) begin
                if (q_a.size() == 0) check("a_valid_without_expect", a_vo, 0);
                else begin
                    e = q_a.pop_front();
                    check("a_dout", a_dout, e.data);
                    check("a_sof", a_sof, e.sof);
                    check("a_latency", cyc, e.cyc);
                end
            end else if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
                e = q_a.pop_front();
                check("a_missing_valid", a_vo, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_f
        exp_t e;
        if (rst_n) begin
            if (f_vo) begin
                if (q_f.size() == 0) check("f_valid_without_expect", f_vo, 0);
                else begin
                    e = q_f.pop_front();
                    check("f_dout", f_dout, e.data);
                    check("f_sof", f_sof, e.sof);
                    check("f_latency", cyc, e.cyc);
                end
            end else if (q_f.size() > 0 && q_f[0].cyc <= cyc) begin
                e = q_f.pop_front();
                check("f_missing_valid", f_vo, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_t
        exp_t e;
        if (rst_n) begin
            if (t_vo) begin
                if (q_t.size() == 0) check("tx_valid_without_expect", t_vo, 0);
                else begin
                    e = q_t.pop_front();
                    check("tx_dout", t_dout, e.data);
                    check("tx_sof", t_sof, e.sof);
                    check("tx_latency", cyc, e.cyc);
                end
            end else if (q_t.size() > 0 && q_t[0].cyc <= cyc) begin
                e = q_t.pop_front();
                check("tx_missing_valid", t_vo, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_r
        exp_t e;
        if (rst_n) begin
            if (r_vo) begin
                if (q_r.size() == 0) check("rx_valid_without_expect", r_vo, 0);
                else begin
                    e = q_r.pop_front();
                    check("rx_dout", r_dout, e.data);
                    check("rx_sof", r_sof, e.sof);
                    check("rx_latency", cyc, e.cyc);
                    if (e.chk) check("rx_round_trip", r_dout, e.plain);
                end
            end else if (q_r.size() > 0 && q_r[0].cyc <= cyc) begin
                e = q_r.pop_front();
                check("rx_missing_valid", r_vo, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_err
        if (rst_n) begin
            check("a_seed_err", a_err, err_exp.exists(cyc));
            check("f_seed_err", f_err, err_exp.exists(1000000 + cyc));
            check("tx_seed_err", t_err, err_exp.exists(2000000 + cyc));
            check("rx_seed_err", r_err, err_exp.exists(3000000 + cyc));
        end
    end

    initial begin
        a_seed = 7'h7F; f_seed = 7'h7F; t_seed = 7'h7F; r_seed = 7'h7F;
        a_load = 0; f_load = 0; t_load = 0; r_load = 0;
        a_desc = 1'b1; f_desc = 1'b0; t_desc = 1'b0; r_desc = 1'b1;
        a_din = '0; f_din = '0; t_din = '0;
        a_vi = 0; f_vi = 0; t_vi = 0;
        for (int ch = 0; ch < 4; ch++) m_seed(ch, 7'h7F);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", a_dout, 0);
        check("reset_valid", a_vo, 0);
        check("reset_sof", a_sof, 0);
        check("reset_seed_err", a_err, 0);
        check("reset_rx_valid", r_vo, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 802.11 reference, frame reload, and self-sync pair start together.
        load_ch(0, 7'h7F);
        load_ch(1, 7'h7F);
        load_ch(2, 7'h55);
        load_ch(3, 7'h00);
        tick;
        tx_on = 1'b1;
        feed_a(8'h00, 1, 8'h0E); feed_f(8'h00, 1, 8'h0E); tick;
        feed_a(8'h00, 1, 8'hF2); feed_f(8'h00, 1, 8'hF2); tick;
        feed_f(8'h00, 0, 8'h00); tick;
        feed_f(8'h00, 1, 8'h0E); tick;
        feed_f(8'h00, 1, 8'hF2); tick;
        feed_f(8'h00, 0, 8'h00); tick;

        // Load wins over a same-cycle word.
        load_ch(0, 7'h7F);
        a_vi  = 1'b1;
        a_din = 8'h3C;
        tick;
        @(negedge clk);
        check("priority_no_valid", a_vo, 0);
        feed_a(8'h00, 1, 8'h0E); tick;

        // Zero seed on the additive instance is replaced by all ones.
        load_ch(0, 7'h00); tick;
        feed_a(8'h00, 1, 8'h0E); tick;
        feed_a(8'h00, 1, 8'hF2); tick;
        for (int i = 0; i < 20; i++) begin
            feed_a(8'($urandom_range(0, 255)), 0, 8'h00);
            tick;
        end

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0)
                load_ch(0, ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(1, 127)));
            else if ($urandom_range(0, 9) < 7)
                feed_a(8'($urandom_range(0, 255)), 0, 8'h00);
            if ($urandom_range(0, 29) == 0)
                load_ch(1, 7'($urandom_range(1, 127)));
            else if ($urandom_range(0, 9) < 7)
                feed_f(8'($urandom_range(0, 255)), 0, 8'h00);
            tick;
        end
        for (int i = 0; i < 200 && tx_idx < 64; i++) tick;
        check("tx_stream_length", tx_idx, 64);
        tx_on = 1'b0;
        repeat (4) tick;

        // Asynchronous reset between edges while a word is on the output.
        feed_a(8'($urandom_range(0, 255)), 0, 8'h00);
        feed_f(8'($urandom_range(0, 255)), 0, 8'h00);
        tick;
        check("pre_reset_valid", a_vo, 1);
        a_vi = 1'b1; a_din = 8'hA5;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", a_vo, 0);
        check("async_sof", a_sof, 0);
        check("async_seed_err", a_err, 0);
        check("async_f_valid", f_vo, 0);
        check("async_dout", a_dout, 0);
        q_a.delete(); q_f.delete(); q_t.delete(); q_r.delete();
        err_exp.delete();
        for (int ch = 0; ch < 4; ch++) m_seed(ch, 7'h7F);
        a_vi = 1'b0;
        tick;
        tick;
        #3;
        rst_n = 1'b1;
        feed_a(8'h00, 1, 8'h0E); feed_f(8'h00, 1, 8'h0E); tick;
        feed_a(8'h00, 1, 8'hF2); tick;
        for (int i = 0; i < 8; i++) begin
            feed_a(8'($urandom_range(0, 255)), 0, 8'h00);
            feed_f(8'($urandom_range(0, 255)), 0, 8'h00);
            tick;
        end
        repeat (4) tick;

        check("a_queue_drained", q_a.size(), 0);
        check("f_queue_drained", q_f.size(), 0);
        check("tx_queue_drained", q_t.size(), 0);
        check("rx_queue_drained", q_r.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
